// File: rtl/updown_sweep_ctrl_if.sv
// Request/status bundle between a sweep requester and the triangle-sweep sequencer.
// The counter feedback (count) and counter controls (mode, cnt_rst) ride in the same bundle.
interface updown_sweep_ctrl_if #(
  parameter int W     = 3,
  parameter int CYC_W = 4
);
  logic             start;
  logic             stop;
  logic [W-1:0]     lo;
  logic [W-1:0]     hi;
  logic [CYC_W-1:0] cycles;
  logic [W-1:0]     count;
  logic             mode;
  logic             cnt_rst;
  logic             busy;
  logic             done;
  logic             err;
  logic [CYC_W-1:0] sweeps;

  modport master (
    output start, stop, lo, hi, cycles, count,
    input  mode, cnt_rst, busy, done, err, sweeps
  );

  modport slave (
    input  start, stop, lo, hi, cycles, count,
    output mode, cnt_rst, busy, done, err, sweeps
  );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Drives an up/down counter through lo->hi->lo triangle sweeps, N times, then parks it at 0.
// Direction is combinational from the fed-back count so the counter never overshoots or wraps.
module updown_sweep_ctrl #(
  parameter int W     = 3,
  parameter int CYC_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_sweep_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [CYC_W-1:0] rem_q, rem_d;
  logic             cnt_rst_q, cnt_rst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      rem_q     <= '0;
      cnt_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      rem_q     <= rem_d;
      cnt_rst_q <= cnt_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    rem_d     = rem_q;
    cnt_rst_d = cnt_rst_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mode      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_rst_d = 1'b1;
        // stop alongside start cancels the request outright, so no error either
        if (bus.start && !bus.stop) begin
          if ((bus.lo < bus.hi) && (bus.cycles != '0)) begin
            lo_d      = bus.lo;
            hi_d      = bus.hi;
            rem_d     = bus.cycles;
            cnt_rst_d = 1'b0;
            state_d   = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      UP: begin
        mode = (bus.count == hi_q);
        if (bus.stop) begin
          state_d   = IDLE;
          cnt_rst_d = 1'b1;
          rem_d     = '0;
        end else if (bus.count == hi_q) begin
          state_d = DOWN;
        end
      end

      DOWN: begin
        mode = (bus.count != lo_q);
        if (bus.stop) begin
          state_d   = IDLE;
          cnt_rst_d = 1'b1;
          rem_d     = '0;
        end else if (bus.count == lo_q) begin
          if (rem_q > CYC_W'(1)) begin
            rem_d   = rem_q - CYC_W'(1);
            state_d = UP;
          end else begin
            rem_d     = '0;
            cnt_rst_d = 1'b1;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_rst_d = 1'b1;
      end
    endcase
  end

  assign bus.mode    = mode;
  assign bus.cnt_rst = cnt_rst_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.sweeps  = rem_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: a behavioural 3-bit up/down counter closes the loop, and each
// sweep is checked edge by edge against a count/sweeps sequence built from the sweep rules.
module tb_updown_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] cnt;
  int         tests;
  int         failed;

  updown_sweep_ctrl_if #(.W(3), .CYC_W(4)) bus ();

  updown_sweep_ctrl #(.W(3), .CYC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter being sequenced: reset held by cnt_rst, otherwise one step per edge.
  always @(posedge clk or posedge bus.cnt_rst) begin
    if (bus.cnt_rst) cnt <= 3'd0;
    else if (bus.mode) cnt <= cnt - 3'd1;
    else cnt <= cnt + 3'd1;
  end
  assign bus.count = cnt;

  typedef struct {
    int lo;
    int hi;
    int cyc;
    int err;
    int lat;
    int poke;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int latency(input int lo, input int hi, input int cyc);
    return hi + (2 * cyc - 1) * (hi - lo) + 1;
  endfunction

  // Start a sweep, then follow it edge by edge until one edge past done.
  task automatic run_sweep(input int lo, input int hi, input int cyc,
                           input int exp_err, input int lat, input int poke);
    int q[$];
    int sw[$];
    int rem;
    bus.lo     = 3'(lo);
    bus.hi     = 3'(hi);
    bus.cycles = 4'(cyc);
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.lo     = 3'($urandom_range(7));
    bus.hi     = 3'($urandom_range(7));
    bus.cycles = 4'($urandom_range(15));
    if (exp_err != 0) begin
      chk("err_pulse", int'(bus.err), 1);
      chk("err_busy", int'(bus.busy), 0);
      chk("err_cnt_rst", int'(bus.cnt_rst), 1);
      tick();
      chk("err_single", int'(bus.err), 0);
      chk("err_busy2", int'(bus.busy), 0);
      return;
    end

    rem = cyc;
    for (int c = 1; c <= hi; c++) begin q.push_back(c); sw.push_back(rem); end
    for (int s = 0; s < cyc; s++) begin
      for (int c = hi - 1; c >= lo; c--) begin q.push_back(c); sw.push_back(rem); end
      rem--;
      if (s < cyc - 1)
        for (int c = lo + 1; c <= hi; c++) begin q.push_back(c); sw.push_back(rem); end
    end

    chk("start_busy", int'(bus.busy), 1);
    chk("start_cnt_rst", int'(bus.cnt_rst), 0);
    chk("start_count", int'(bus.count), 0);
    chk("start_sweeps", int'(bus.sweeps), cyc);
    chk("start_err", int'(bus.err), 0);

    for (int k = 1; k < lat; k++) begin
      if (k == poke) begin
        bus.start  = 1'b1;
        bus.lo     = 3'd0;
        bus.hi     = 3'd7;
        bus.cycles = 4'd9;
      end
      tick();
      bus.start = 1'b0;
      chk($sformatf("count_e%0d", k), int'(bus.count), (k <= q.size()) ? q[k-1] : -1);
      chk($sformatf("sweeps_e%0d", k), int'(bus.sweeps), (k <= sw.size()) ? sw[k-1] : -1);
      chk($sformatf("busy_e%0d", k), int'(bus.busy), 1);
      chk($sformatf("done_e%0d", k), int'(bus.done), 0);
    end
    tick();
    chk("done_pulse", int'(bus.done), 1);
    chk("done_busy", int'(bus.busy), 0);
    chk("done_cnt_rst", int'(bus.cnt_rst), 1);
    chk("done_count", int'(bus.count), 0);
    chk("done_sweeps", int'(bus.sweeps), 0);
    tick();
    chk("done_single", int'(bus.done), 0);
    chk("idle_mode", int'(bus.mode), 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_cnt_rst"}, int'(bus.cnt_rst), 1);
    chk({tag, "_mode"}, int'(bus.mode), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_sweeps"}, int'(bus.sweeps), 0);
    chk({tag, "_count"}, int'(bus.count), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.lo     = 3'd0;
    bus.hi     = 3'd0;
    bus.cycles = 4'd0;

    vecs[0] = '{lo: 2, hi: 4, cyc: 1, err: 0, lat: 7,  poke: 0};
    vecs[1] = '{lo: 2, hi: 4, cyc: 2, err: 0, lat: 11, poke: 0};
    vecs[2] = '{lo: 0, hi: 7, cyc: 1, err: 0, lat: 15, poke: 0};
    vecs[3] = '{lo: 5, hi: 5, cyc: 1, err: 1, lat: 0,  poke: 0};
    vecs[4] = '{lo: 6, hi: 3, cyc: 2, err: 1, lat: 0,  poke: 0};
    vecs[5] = '{lo: 1, hi: 3, cyc: 0, err: 1, lat: 0,  poke: 0};
    vecs[6] = '{lo: 0, hi: 1, cyc: 3, err: 0, lat: 7,  poke: 0};
    vecs[7] = '{lo: 6, hi: 7, cyc: 2, err: 0, lat: 11, poke: 0};
    vecs[8] = '{lo: 0, hi: 7, cyc: 2, err: 0, lat: 29, poke: 0};
    vecs[9] = '{lo: 1, hi: 3, cyc: 1, err: 0, lat: 6,  poke: 2};

    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    foreach (vecs[i])
      run_sweep(vecs[i].lo, vecs[i].hi, vecs[i].cyc, vecs[i].err, vecs[i].lat, vecs[i].poke);

    // stop together with a valid start in IDLE: nothing happens
    bus.lo = 3'd1; bus.hi = 3'd5; bus.cycles = 4'd1;
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    check_idle("stop_start");
    tick();
    chk("stop_start_err2", int'(bus.err), 0);

    // stop on the cycle the final lo is observed beats completion
    bus.lo = 3'd2; bus.hi = 3'd4; bus.cycles = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    chk("abort_at_lo_count", int'(bus.count), 2);
    chk("abort_at_lo_busy", int'(bus.busy), 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_idle("abort");
    tick();
    chk("abort_no_late_done", int'(bus.done), 0);

    // reset while counting down through 3
    bus.lo = 3'd2; bus.hi = 3'd4; bus.cycles = 4'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("pre_rst_count", int'(bus.count), 3);
    chk("pre_rst_mode", int'(bus.mode), 1);
    rst = 1'b1;
    #1;
    check_idle("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_idle("after_rst");

    // randomized sweeps, including invalid argument combinations
    for (int r = 0; r < 24; r++) begin
      int lo, hi, cyc, bad;
      lo  = int'($urandom_range(7));
      hi  = int'($urandom_range(7));
      cyc = int'($urandom_range(4));
      bad = (lo >= hi || cyc == 0) ? 1 : 0;
      run_sweep(lo, hi, cyc, bad, bad ? 0 : latency(lo, hi, cyc),
                int'($urandom_range(3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
